spdif_sample_sched: RTL and testbench

- Sits between the audio sources and the SPDIF transmitter's 16-bit L/R sample port.
- Arbitrates between two stereo sources (A, B) with valid/ready handshakes and buffers samples in a small FIFO.
- Answers each transmitter sample-request pulse with the next stereo pair.
- Mutes output for a fixed number of frames around a source switch, and flags underruns.

---
 rtl/spdif_pkg.sv | 17 +
 rtl/spdif_pair_fifo.sv | 97 +++++++++
 rtl/spdif_sample_sched.sv | 212 +++++++++++++++++++++
 tb/tb_spdif_sample_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// Shared types and constants for the SPDIF sample scheduler.
package spdif_pkg;

  localparam int SPDIF_SW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUTE = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [SPDIF_SW-1:0] l;
    logic [SPDIF_SW-1:0] r;
  } pair_t;

endpackage

// File: rtl/spdif_pair_fifo.sv
// Synchronous DEPTH x 32-bit stereo-pair FIFO; flush beats push/pop.
module spdif_pair_fifo
  import spdif_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic [2*SPDIF_SW-1:0]     din_i,
  output logic [2*SPDIF_SW-1:0]     dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [2*SPDIF_SW-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  do_push_s, do_pop_s;

  // Guard against overflow/underflow; a flush discards both operations.
  always_comb begin
    do_push_s = push_i && !full_q && !flush_i;
    do_pop_s  = pop_i && !empty_q && !flush_i;
  end

  // Pointer and occupancy next state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (do_pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
    full_d  = (cnt_d == CNT_FULL);
    empty_d = (cnt_d == '0);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array; contents are only meaningful below the count.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = cnt_q;

endmodule

// File: rtl/spdif_sample_sched.sv
// Two-source stereo sample scheduler feeding the SPDIF transmitter.
module spdif_sample_sched
  import spdif_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int MUTE_FRAMES   = 8,
  parameter int UNDERRUN_ZERO = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   src_sel_i,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [15:0]            a_l_i,
  input  logic [15:0]            a_r_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [15:0]            b_l_i,
  input  logic [15:0]            b_r_i,
  input  logic                   sample_req_i,
  output logic [15:0]            audio_l_o,
  output logic [15:0]            audio_r_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   active_src_o,
  output logic                   muting_o,
  output logic                   underrun_o,
  output logic [7:0]             underrun_cnt_o
);

  localparam logic [7:0] MUTE_LOAD = 8'(MUTE_FRAMES);

  state_e      state_q, state_d;
  logic        active_src_q, active_src_d;
  logic [7:0]  mute_cnt_q, mute_cnt_d;
  pair_t       audio_q, audio_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  ucnt_q, ucnt_d;
  logic        muting_q, muting_d;

  logic        src_switch_s;
  logic        sel_valid_s;
  logic        fifo_push_s, fifo_pop_s, fifo_flush_s;
  logic        fifo_full_s, fifo_empty_s;
  pair_t       fifo_din_s, fifo_head_s;

  assign src_switch_s = (src_sel_i != active_src_q);
  assign sel_valid_s  = active_src_q ? b_valid_i : a_valid_i;
  assign fifo_din_s   = active_src_q ? pair_t'({b_l_i, b_r_i}) : pair_t'({a_l_i, a_r_i});

  // Only the latched source sees ready, and only in RUN with room left.
  assign a_ready_o = (state_q == RUN) && !active_src_q && !fifo_full_s;
  assign b_ready_o = (state_q == RUN) && active_src_q && !fifo_full_s;

  spdif_pair_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push_s),
    .pop_i   (fifo_pop_s),
    .flush_i (fifo_flush_s),
    .din_i   (fifo_din_s),
    .dout_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (level_o)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: disable wins, then a source switch, then mute expiry.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = MUTE;
        MUTE: begin
          if (src_switch_s) begin
            state_d = MUTE;
          end else if (sample_req_i && (mute_cnt_q == 8'd1)) begin
            state_d = RUN;
          end else begin
            state_d = MUTE;
          end
        end
        RUN: begin
          if (src_switch_s) begin
            state_d = MUTE;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values for each state.
  always_comb begin
    active_src_d = active_src_q;
    mute_cnt_d   = mute_cnt_q;
    audio_d      = audio_q;
    underrun_d   = 1'b0;
    ucnt_d       = ucnt_q;
    fifo_push_s  = 1'b0;
    fifo_pop_s   = 1'b0;
    fifo_flush_s = 1'b0;
    if (!enable_i) begin
      audio_d      = '0;
      ucnt_d       = 8'd0;
      fifo_flush_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          audio_d      = '0;
          ucnt_d       = 8'd0;
          fifo_flush_s = 1'b1;
          active_src_d = src_sel_i;
          mute_cnt_d   = MUTE_LOAD;
        end
        MUTE: begin
          fifo_flush_s = 1'b1;
          if (sample_req_i) begin
            audio_d = '0;
          end else begin
            audio_d = audio_q;
          end
          if (src_switch_s) begin
            active_src_d = src_sel_i;
            mute_cnt_d   = MUTE_LOAD;
          end else if (sample_req_i) begin
            mute_cnt_d = mute_cnt_q - 8'd1;
          end else begin
            mute_cnt_d = mute_cnt_q;
          end
        end
        RUN: begin
          if (src_switch_s) begin
            // Any push or request in this cycle is dropped with the flush.
            active_src_d = src_sel_i;
            mute_cnt_d   = MUTE_LOAD;
            fifo_flush_s = 1'b1;
          end else begin
            fifo_push_s = sel_valid_s && !fifo_full_s;
            if (sample_req_i) begin
              if (!fifo_empty_s) begin
                fifo_pop_s = 1'b1;
                audio_d    = fifo_head_s;
              end else begin
                underrun_d = 1'b1;
                if (ucnt_q != 8'd255) begin
                  ucnt_d = ucnt_q + 8'd1;
                end else begin
                  ucnt_d = ucnt_q;
                end
                if (UNDERRUN_ZERO != 0) begin
                  audio_d = '0;
                end else begin
                  audio_d = audio_q;
                end
              end
            end else begin
              audio_d = audio_q;
            end
          end
        end
        default: begin
          audio_d      = '0;
          fifo_flush_s = 1'b1;
        end
      endcase
    end
    muting_d = (state_d != RUN);
  end

  // Registered outputs and control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_src_q <= 1'b0;
      mute_cnt_q   <= 8'd0;
      audio_q      <= '0;
      underrun_q   <= 1'b0;
      ucnt_q       <= 8'd0;
      muting_q     <= 1'b0;
    end else begin
      active_src_q <= active_src_d;
      mute_cnt_q   <= mute_cnt_d;
      audio_q      <= audio_d;
      underrun_q   <= underrun_d;
      ucnt_q       <= ucnt_d;
      muting_q     <= muting_d;
    end
  end

  assign audio_l_o      = audio_q.l;
  assign audio_r_o      = audio_q.r;
  assign active_src_o   = active_src_q;
  assign muting_o       = muting_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt_q;

endmodule

// File: tb/tb_spdif_sample_sched.sv
// Self-checking bench for spdif_sample_sched (DEPTH=4, MUTE_FRAMES=8, UNDERRUN_ZERO=0).
module tb_spdif_sample_sched;

  localparam int DEPTH = 4;
  localparam int MF    = 8;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } pr_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [2:0]  exp_level;
    logic        exp_ready;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i, src_sel_i;
  logic        a_valid_i, b_valid_i, sample_req_i;
  logic        a_ready_o, b_ready_o;
  logic [15:0] a_l_i, a_r_i, b_l_i, b_r_i;
  logic [15:0] audio_l_o, audio_r_o;
  logic [2:0]  level_o;
  logic        active_src_o, muting_o, underrun_o;
  logic [7:0]  underrun_cnt_o;

  int   n_chk = 0;
  int   n_fail = 0;
  pr_t  exp_q[$];
  pr_t  last_p;
  int   ucnt_m;
  vec_t tbl[4];

  spdif_sample_sched #(.DEPTH(DEPTH), .MUTE_FRAMES(MF), .UNDERRUN_ZERO(0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .src_sel_i(src_sel_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_l_i(a_l_i), .a_r_i(a_r_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_l_i(b_l_i), .b_r_i(b_r_i),
    .sample_req_i(sample_req_i), .audio_l_o(audio_l_o), .audio_r_o(audio_r_o),
    .level_o(level_o), .active_src_o(active_src_o), .muting_o(muting_o),
    .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One request in MUTE: outputs go to zero, muting reflects remaining count.
  task automatic mute_req(input string nm, input logic exp_muting);
    sample_req_i = 1'b1;
    tick();
    sample_req_i = 1'b0;
    chk({nm, "_l"}, {16'd0, audio_l_o}, 32'd0);
    chk({nm, "_r"}, {16'd0, audio_r_o}, 32'd0);
    chk({nm, "_muting"}, {31'd0, muting_o}, {31'd0, exp_muting});
    last_p = '{16'h0000, 16'h0000};
    tick();
  endtask

  task automatic mute_frames(input string nm, input int n, input logic ends_run);
    for (int i = 0; i < n; i++) begin
      mute_req(nm, !(ends_run && (i == n - 1)));
    end
  endtask

  // One request in RUN, checked against the scoreboard.
  task automatic run_req(input string nm);
    pr_t e;
    logic exp_ur;
    chk({nm, "_pre_l"}, {16'd0, audio_l_o}, {16'd0, last_p.l});
    sample_req_i = 1'b1;
    tick();
    sample_req_i = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_ur = 1'b0;
    end else begin
      e = last_p;
      exp_ur = 1'b1;
      if (ucnt_m < 255) ucnt_m++;
    end
    last_p = e;
    chk({nm, "_l"}, {16'd0, audio_l_o}, {16'd0, e.l});
    chk({nm, "_r"}, {16'd0, audio_r_o}, {16'd0, e.r});
    chk({nm, "_underrun"}, {31'd0, underrun_o}, {31'd0, exp_ur});
    chk({nm, "_level"}, {29'd0, level_o}, exp_q.size());
    tick();
    chk({nm, "_underrun_end"}, {31'd0, underrun_o}, 32'd0);
    chk({nm, "_ucnt"}, {24'd0, underrun_cnt_o}, ucnt_m);
  endtask

  task automatic push(input string nm, input logic src, input logic [15:0] l, input logic [15:0] r);
    logic exp_rdy;
    exp_rdy = (exp_q.size() < DEPTH);
    if (src) begin
      b_l_i = l; b_r_i = r; b_valid_i = 1'b1;
      chk({nm, "_ready"}, {31'd0, b_ready_o}, {31'd0, exp_rdy});
    end else begin
      a_l_i = l; a_r_i = r; a_valid_i = 1'b1;
      chk({nm, "_ready"}, {31'd0, a_ready_o}, {31'd0, exp_rdy});
    end
    if (exp_rdy) exp_q.push_back('{l, r});
    tick();
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    chk({nm, "_level"}, {29'd0, level_o}, exp_q.size());
  endtask

  initial begin
    pr_t e;
    tbl[0] = '{16'h1111, 16'h2222, 3'd1, 1'b1};
    tbl[1] = '{16'h2222, 16'h3333, 3'd2, 1'b1};
    tbl[2] = '{16'h3333, 16'h4444, 3'd3, 1'b1};
    tbl[3] = '{16'h4444, 16'h5555, 3'd4, 1'b0};
    last_p = '{16'h0000, 16'h0000};
    ucnt_m = 0;

    rst_ni = 1'b0; enable_i = 1'b0; src_sel_i = 1'b0;
    a_valid_i = 1'b0; b_valid_i = 1'b0; sample_req_i = 1'b0;
    a_l_i = 16'h0; a_r_i = 16'h0; b_l_i = 16'h0; b_r_i = 16'h0;
    #2;
    chk("rst_audio", {audio_l_o, audio_r_o}, 32'd0);
    chk("rst_level", {29'd0, level_o}, 32'd0);
    chk("rst_flags", {27'd0, a_ready_o, b_ready_o, active_src_o, muting_o, underrun_o}, 32'd0);
    chk("rst_ucnt", {24'd0, underrun_cnt_o}, 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    chk("idle_muting", {31'd0, muting_o}, 32'd1);

    // A request while idle is ignored.
    sample_req_i = 1'b1;
    tick();
    sample_req_i = 1'b0;
    chk("idle_req_audio", {audio_l_o, audio_r_o}, 32'd0);
    chk("idle_req_underrun", {31'd0, underrun_o}, 32'd0);
    tick();
    chk("idle_req_ucnt", {24'd0, underrun_cnt_o}, 32'd0);

    // Enable with source A: 8 muted frames then RUN.
    enable_i = 1'b1;
    tick();
    chk("mute_entry_muting", {31'd0, muting_o}, 32'd1);
    chk("mute_entry_active", {31'd0, active_src_o}, 32'd0);
    chk("mute_entry_ready", {30'd0, a_ready_o, b_ready_o}, 32'd0);
    mute_frames("mute_a", MF, 1'b1);
    chk("run_a_ready", {30'd0, a_ready_o, b_ready_o}, 32'b10);

    // Fill the FIFO from the vector table.
    for (int i = 0; i < 4; i++) begin
      push("tbl_push", 1'b0, tbl[i].l, tbl[i].r);
      chk("tbl_level", {29'd0, level_o}, {29'd0, tbl[i].exp_level});
      chk("tbl_ready", {31'd0, a_ready_o}, {31'd0, tbl[i].exp_ready});
    end
    push("push_full", 1'b0, 16'hDEAD, 16'hBEEF);

    // Drain in order, then underrun with held outputs.
    for (int i = 0; i < 4; i++) run_req("drain");
    run_req("underrun1");
    chk("underrun1_cnt", {24'd0, underrun_cnt_o}, 32'd1);
    chk("underrun1_hold", {audio_l_o, audio_r_o}, 32'h44445555);
    for (int i = 0; i < 299; i++) run_req("underrun_many");
    chk("underrun_sat", {24'd0, underrun_cnt_o}, 32'd255);

    // Source switch with level 2 flushes and mutes.
    push("pre_sw", 1'b0, 16'h1001, 16'h2001);
    push("pre_sw", 1'b0, 16'h1002, 16'h2002);
    src_sel_i = 1'b1;
    tick();
    exp_q.delete();
    chk("sw_level", {29'd0, level_o}, 32'd0);
    chk("sw_muting", {31'd0, muting_o}, 32'd1);
    chk("sw_active", {31'd0, active_src_o}, 32'd1);
    chk("sw_ready", {30'd0, a_ready_o, b_ready_o}, 32'd0);
    b_l_i = 16'hB0B0; b_r_i = 16'hB1B1; b_valid_i = 1'b1;
    mute_frames("sw_mute", 4, 1'b0);
    chk("sw_mute_nopush", {29'd0, level_o}, 32'd0);
    b_valid_i = 1'b0;
    src_sel_i = 1'b0;
    tick();
    chk("restart_active", {31'd0, active_src_o}, 32'd0);
    mute_frames("restart_mute", MF, 1'b1);
    chk("restart_run_ready", {30'd0, a_ready_o, b_ready_o}, 32'b10);

    // Switch to B and stream B data.
    src_sel_i = 1'b1;
    tick();
    mute_frames("mute_b", MF, 1'b1);
    chk("run_b_ready", {30'd0, a_ready_o, b_ready_o}, 32'b01);
    push("push_b", 1'b1, 16'hB0B0, 16'hB1B1);
    run_req("req_b");

    // Push and pop in the same cycle at level 1.
    push("push_b2", 1'b1, 16'hB2B2, 16'hB3B3);
    b_l_i = 16'hB4B4; b_r_i = 16'hB5B5; b_valid_i = 1'b1; sample_req_i = 1'b1;
    exp_q.push_back('{16'hB4B4, 16'hB5B5});
    tick();
    b_valid_i = 1'b0; sample_req_i = 1'b0;
    e = exp_q.pop_front();
    last_p = e;
    chk("pp_level", {29'd0, level_o}, 32'd1);
    chk("pp_audio", {audio_l_o, audio_r_o}, {e.l, e.r});
    tick();
    run_req("pp_next");

    // Disable mid-RUN: straight to IDLE.
    push("pre_dis", 1'b1, 16'hC0C0, 16'hC1C1);
    enable_i = 1'b0;
    tick();
    chk("dis_audio", {audio_l_o, audio_r_o}, 32'd0);
    chk("dis_ucnt", {24'd0, underrun_cnt_o}, 32'd0);
    chk("dis_level", {29'd0, level_o}, 32'd0);
    chk("dis_muting", {31'd0, muting_o}, 32'd1);
    chk("dis_ready", {30'd0, a_ready_o, b_ready_o}, 32'd0);

    // Asynchronous reset in the middle of a cycle.
    enable_i = 1'b1;
    tick();
    chk("ar_active_pre", {31'd0, active_src_o}, 32'd1);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("ar_active", {31'd0, active_src_o}, 32'd0);
    chk("ar_muting", {31'd0, muting_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
